// File: rtl/uart_pkg.sv
// Shared UART types and constants for the receiver, transmitter and clock generator.
package uart_pkg;
   localparam int UART_DATA_BITS          = 8;
   localparam int UART_OVERSAMPLE_DEFAULT = 16;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      WAIT_HIGH
   } rx_state_e;
endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchroniser for the asynchronous rx line; resets to the idle (high) level.
module uart_rx_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic sys_clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);
   logic [SYNC_STAGES-1:0] sync_q, sync_d;

   always_comb sync_d = {sync_q[SYNC_STAGES-2:0], d};

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) sync_q <= '1;
      else        sync_q <= sync_d;
   end

   assign q = sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/uart_receiver.sv
// Oversampling 8N1 UART receiver with single-cycle valid / error strobes.
// Define UART_RX_PARITY_EN to receive 8E1 frames and report parity errors.
module uart_receiver
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE  = UART_OVERSAMPLE_DEFAULT,
   parameter int SYNC_STAGES = 2
) (
   input  logic       sys_clk,
   input  logic       rst_n,
   input  logic       rx_clk_en,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_frame_err,
   output logic       rx_parity_err,
   output logic       rx_busy
);
   localparam int TW = $clog2(OVERSAMPLE);
   localparam logic [TW-1:0] HALF_M1 = TW'(OVERSAMPLE/2 - 1);
   localparam logic [TW-1:0] LAST    = TW'(OVERSAMPLE - 1);

   logic rx_s;

   uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .sys_clk (sys_clk),
      .rst_n   (rst_n),
      .d       (rx),
      .q       (rx_s)
   );

   rx_state_e                   state_q, state_d;
   logic [TW-1:0]               tick_q, tick_d;
   logic [2:0]                  bit_q, bit_d;
   logic [UART_DATA_BITS-1:0]   shreg_q, shreg_d;
   logic [UART_DATA_BITS-1:0]   data_q, data_d;
   logic                        valid_q, valid_d;
   logic                        ferr_q, ferr_d;
   logic                        busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
   logic                        par_q, par_d;
   logic                        perr_q, perr_d;
`endif

   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_d   = par_q;
      perr_d  = 1'b0;
`endif
      if (rx_clk_en) begin
         unique case (state_q)
            IDLE: begin
               if (!rx_s) begin
                  state_d = START;
                  tick_d  = '0;
               end
            end
            START: begin
               // Re-check the line half a bit in to reject glitches.
               if (tick_q == HALF_M1) begin
                  tick_d  = '0;
                  bit_d   = '0;
                  state_d = rx_s ? IDLE : DATA;
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end
            DATA: begin
               if (tick_q == LAST) begin
                  tick_d  = '0;
                  shreg_d = {rx_s, shreg_q[UART_DATA_BITS-1:1]};
                  bit_d   = bit_q + 1'b1;
                  if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state_d = PARITY;
`else
                     state_d = STOP;
`endif
                  end
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end
            PARITY: begin
`ifdef UART_RX_PARITY_EN
               if (tick_q == LAST) begin
                  tick_d  = '0;
                  par_d   = rx_s;
                  state_d = STOP;
               end else begin
                  tick_d = tick_q + 1'b1;
               end
`else
               state_d = IDLE;
`endif
            end
            STOP: begin
               // Returning to IDLE mid stop bit lets a back-to-back start bit be caught.
               if (tick_q == LAST) begin
                  tick_d = '0;
`ifdef UART_RX_PARITY_EN
                  perr_d = ^{shreg_q, par_q};
`endif
                  if (rx_s) begin
                     state_d = IDLE;
`ifdef UART_RX_PARITY_EN
                     if (!perr_d) begin
                        data_d  = shreg_q;
                        valid_d = 1'b1;
                     end
`else
                     data_d  = shreg_q;
                     valid_d = 1'b1;
`endif
                  end else begin
                     ferr_d  = 1'b1;
                     state_d = WAIT_HIGH;
                  end
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end
            WAIT_HIGH: begin
               if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         tick_q  <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_q   <= 1'b0;
         perr_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
         busy_q  <= busy_d;
`ifdef UART_RX_PARITY_EN
         par_q   <= par_d;
         perr_q  <= perr_d;
`endif
      end
   end

   assign rx_data      = data_q;
   assign rx_valid     = valid_q;
   assign rx_frame_err = ferr_q;
   assign rx_busy      = busy_q;
`ifdef UART_RX_PARITY_EN
   assign rx_parity_err = perr_q;
`else
   assign rx_parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: bit-banged frames, strobe monitor, in-order byte checks.
module tb_uart_receiver;
   localparam int OS = 16;

   logic       sys_clk = 1'b0;
   logic       rst_n   = 1'b0;
   logic       rx_clk_en = 1'b0;
   logic       rx = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid, rx_frame_err, rx_parity_err, rx_busy;

   int npass = 0;
   int ntot  = 0;
   int nvalid = 0, nferr = 0, nperr = 0;
   int div = 3;
   int div_cnt = 0;
   logic [7:0] got[$];

   uart_receiver #(.OVERSAMPLE(OS), .SYNC_STAGES(2)) dut (
      .sys_clk       (sys_clk),
      .rst_n         (rst_n),
      .rx_clk_en     (rx_clk_en),
      .rx            (rx),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .rx_frame_err  (rx_frame_err),
      .rx_parity_err (rx_parity_err),
      .rx_busy       (rx_busy)
   );

   always #5 sys_clk = ~sys_clk;

   // Tick generator changes on the falling edge so it is stable at the rising edge.
   always @(negedge sys_clk) begin
      if (div_cnt >= div - 1) begin
         div_cnt = 0;
         rx_clk_en = 1'b1;
      end else begin
         div_cnt = div_cnt + 1;
         rx_clk_en = 1'b0;
      end
   end

   always @(negedge sys_clk) begin
      if (rx_valid) begin
         nvalid = nvalid + 1;
         got.push_back(rx_data);
      end
      if (rx_frame_err)  nferr = nferr + 1;
      if (rx_parity_err) nperr = nperr + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic ticks(input int n);
      repeat (n) begin
         @(posedge sys_clk);
         while (!rx_clk_en) @(posedge sys_clk);
      end
      #1;
   endtask

   task automatic send_bit(input logic b);
      rx = b;
      ticks(OS);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop, input logic pflip,
                             input logic chk_busy);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) begin
         send_bit(d[i]);
         if (chk_busy && i == 3) chk("busy_mid_frame", 32'(rx_busy), 32'd1);
      end
`ifdef UART_RX_PARITY_EN
      send_bit((^d) ^ pflip);
`else
      if (pflip) rx = 1'b1;
`endif
      send_bit(stop);
   endtask

   initial begin
      int v0, f0;
      logic [7:0] exp_b;
      repeat (3) @(posedge sys_clk);
      #1 rst_n = 1'b1;

      // Idle line after reset
      ticks(100);
      @(negedge sys_clk);
      chk("reset_data",  32'(rx_data), 32'h00);
      chk("reset_busy",  32'(rx_busy), 32'd0);
      chk("idle_valid_cnt", 32'(nvalid), 32'd0);
      chk("idle_ferr_cnt",  32'(nferr),  32'd0);
      chk("idle_perr_cnt",  32'(nperr),  32'd0);

      // Single frame 0xA5
      send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
      ticks(4);
      @(negedge sys_clk);
      chk("a5_valid_cnt", 32'(nvalid), 32'd1);
      chk("a5_data",      32'(rx_data), 32'hA5);
      chk("a5_busy_after", 32'(rx_busy), 32'd0);

      // Glitch shorter than half a bit
      rx = 1'b0;
      ticks(4);
      @(negedge sys_clk);
      chk("glitch_busy_during", 32'(rx_busy), 32'd1);
      rx = 1'b1;
      ticks(16);
      @(negedge sys_clk);
      chk("glitch_busy_after", 32'(rx_busy), 32'd0);
      chk("glitch_valid_cnt",  32'(nvalid), 32'd1);
      chk("glitch_ferr_cnt",   32'(nferr),  32'd0);

      // Framing error, line held low, then a good frame
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
      rx = 1'b0;
      ticks(3 * OS);
      @(negedge sys_clk);
      chk("ferr_cnt",        32'(nferr),  32'd1);
      chk("ferr_data_hold",  32'(rx_data), 32'hA5);
      chk("ferr_valid_cnt",  32'(nvalid), 32'd1);
      chk("ferr_busy_low",   32'(rx_busy), 32'd1);
      rx = 1'b1;
      ticks(2 * OS);
      @(negedge sys_clk);
      chk("ferr_no_restart", 32'(nferr), 32'd1);
      send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
      ticks(4);
      @(negedge sys_clk);
      chk("5a_valid_cnt", 32'(nvalid), 32'd2);
      chk("5a_data",      32'(rx_data), 32'h5A);

      // Back-to-back frames then reset mid-frame
      got.delete();
      send_frame(8'h00, 1'b1, 1'b0, 1'b0);
      send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
      send_frame(8'h81, 1'b1, 1'b0, 1'b0);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      @(negedge sys_clk);
      chk("b2b_valid_cnt", 32'(nvalid), 32'd5);
      chk("b2b_size", 32'(got.size()), 32'd3);
      if (got.size() == 3) begin
         chk("b2b_byte0", 32'(got[0]), 32'h00);
         chk("b2b_byte1", 32'(got[1]), 32'hFF);
         chk("b2b_byte2", 32'(got[2]), 32'h81);
      end
      chk("abort_busy_before", 32'(rx_busy), 32'd1);
      rst_n = 1'b0;
      @(negedge sys_clk);
      chk("abort_data",  32'(rx_data), 32'h00);
      chk("abort_busy",  32'(rx_busy), 32'd0);
      chk("abort_valid", 32'(rx_valid), 32'd0);
      rx = 1'b1;
      @(posedge sys_clk);
      #1 rst_n = 1'b1;
      v0 = nvalid;
      f0 = nferr;
      ticks(200);
      @(negedge sys_clk);
      chk("abort_no_valid", 32'(nvalid), 32'(v0));
      chk("abort_no_ferr",  32'(nferr),  32'(f0));
      chk("abort_data_after", 32'(rx_data), 32'h00);

      // Full byte sweep, one tick per clock
      div = 1;
      got.delete();
      for (int b = 0; b < 256; b++) send_frame(8'(b), 1'b1, 1'b0, 1'b0);
      ticks(4);
      @(negedge sys_clk);
      chk("sweep_size", 32'(got.size()), 32'd256);
      for (int b = 0; b < 256; b++) begin
         exp_b = 8'(b);
         if (b < got.size()) chk("sweep_byte", 32'(got[b]), 32'(exp_b));
      end
      chk("sweep_ferr", 32'(nferr), 32'(f0));

`ifdef UART_RX_PARITY_EN
      v0 = nvalid;
      send_frame(8'h0F, 1'b1, 1'b1, 1'b0);
      ticks(4);
      @(negedge sys_clk);
      chk("par_err_cnt",   32'(nperr), 32'd1);
      chk("par_no_valid",  32'(nvalid), 32'(v0));
      chk("par_data_hold", 32'(rx_data), 32'hFF);
`else
      chk("par_tied_cnt", 32'(nperr), 32'd0);
`endif

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end
endmodule
